// File: rtl/dmem_loader_pkg.sv
// Shared definitions for the dmem preloader: FSM encoding, stream framing constants
// and the header range check.
package dmem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLen0,
    StLen1,
    StData,
    StCsum,
    StFlush,
    StDone,
    StErr
  } state_e;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;

  // Length must fit both the configured cap and the window above base (no address wrap).
  function automatic logic len_ok(input logic [15:0] n, input int unsigned base,
                                  input int unsigned max_words, input int unsigned addr_w);
    return (32'(n) <= max_words) && ((64'(base) + 64'(n)) <= (64'(1) << addr_w));
  endfunction

endpackage

// File: rtl/dmem_loader_if.sv
// Valid/ready byte stream feeding the dmem preloader.
interface dmem_loader_if;
  logic       valid;
  logic [7:0] data;
  logic       ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/dmem_loader_byte_packer.sv
// Little-endian byte-to-word packer; word_valid is a combinational pulse on the 4th byte.
module dmem_loader_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  lane_q;
  logic [23:0] sr_q;

  assign word_valid = in_valid && (lane_q == 2'd3);
  assign word       = {in_data, sr_q};

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lane_q <= 2'd0;
      sr_q   <= 24'd0;
    end else if (in_valid) begin
      lane_q <= lane_q + 2'd1;
      sr_q   <= {in_data, sr_q[23:8]};
    end
  end

endmodule

// File: rtl/dmem_loader.sv
// Byte-stream preloader for dmem; holds the core in reset until a clean load completes.
// Optional trailer checksum: define DMEM_LOADER_CHECKSUM_EN.
module dmem_loader
  import dmem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  dmem_loader_if.slave      s,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_e      state_q, state_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [15:0] nwords_q, nwords_d;
  logic [15:0] widx_q, widx_d;
  logic [7:0]  xor_q, xor_d;
  logic        flush_q, flush_d;

  logic        accept, start_ok, data_beat, word_valid;
  logic [31:0] word;
  logic [15:0] hdr_n;

  assign s.ready   = state_q inside {StLen0, StLen1, StData, StCsum};
  assign accept    = s.valid && s.ready;
  assign start_ok  = start && (state_q inside {StIdle, StDone, StErr});
  assign data_beat = accept && (state_q == StData);
  assign hdr_n     = {s.data, len_lo_q};

  dmem_loader_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok),
    .in_valid   (data_beat),
    .in_data    (s.data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    nwords_d = nwords_q;
    widx_d   = widx_q;
    xor_d    = xor_q;
    flush_d  = flush_q;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d  = StLen0;
          nwords_d = 16'd0;
          widx_d   = 16'd0;
          xor_d    = 8'd0;
          flush_d  = 1'b0;
        end
      end
      StLen0: begin
        if (accept) begin
          len_lo_d = s.data;
          state_d  = StLen1;
        end
      end
      StLen1: begin
        if (accept) begin
          nwords_d = hdr_n;
          if (!len_ok(hdr_n, BASE_ADDR, MAX_WORDS, ADDR_W)) begin
            state_d = StErr;
          end else if (hdr_n == 16'd0) begin
`ifdef DMEM_LOADER_CHECKSUM_EN
            state_d = StCsum;
`else
            state_d = StDone;
`endif
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          xor_d = xor_q ^ s.data;
          if (word_valid) begin
            widx_d = widx_q + 16'd1;
            if (widx_q + 16'd1 == nwords_q) begin
`ifdef DMEM_LOADER_CHECKSUM_EN
              state_d = StCsum;
`else
              state_d = StFlush;
`endif
            end
          end
        end
      end
      StCsum: begin
        if (accept) state_d = (s.data == xor_q) ? StFlush : StErr;
      end
      // Two cycles here so the core sees the final write settle before release.
      StFlush: begin
        flush_d = 1'b1;
        if (flush_q) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      len_lo_q  <= 8'd0;
      nwords_q  <= 16'd0;
      widx_q    <= 16'd0;
      xor_q     <= 8'd0;
      flush_q   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      nwords_q <= nwords_d;
      widx_q   <= widx_d;
      xor_q    <= xor_d;
      flush_q  <= flush_d;
      mem_we   <= word_valid;
      if (word_valid) begin
        mem_addr  <= ADDR_W'(BASE_ADDR) + ADDR_W'(widx_q);
        mem_wdata <= word;
      end
    end
  end

  assign busy     = state_q inside {StLen0, StLen1, StData, StCsum, StFlush};
  assign done     = (state_q == StDone);
  assign error    = (state_q == StErr);
  assign core_rst = (state_q != StDone);

endmodule
